// File: rtl/irq_defs_pkg.sv
// rtl/irq_defs_pkg.sv - shared constants and helpers for the interrupt controller
package irq_defs;

  localparam int NUM_IRQ     = 8;
  localparam int VEC_ANY_BIT = 7;

  localparam logic [2:0] IRQ_PEND   = 3'd0;
  localparam logic [2:0] IRQ_MASK   = 3'd1;
  localparam logic [2:0] IRQ_MODE   = 3'd2;
  localparam logic [2:0] IRQ_VECTOR = 3'd3;
  localparam logic [2:0] IRQ_ISR    = 3'd4;
  localparam logic [2:0] IRQ_STATUS = 3'd5;

  // One-hot decode of a source index
  function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [2:0] idx);
    logic [NUM_IRQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - lowest-set-bit priority encoder, 8 inputs
module prio_enc8 (
  input  logic [7:0] in_bits,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the top so the lowest set bit is the last one to win
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (in_bits[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - eight-input prioritised, nesting interrupt controller
module irq_ctrl
  import irq_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  input  logic [7:0] irq_in,
  output logic       intr
);

  logic [7:0] irq_q;
  logic [7:0] pend_r;   // latched edge-mode pending bits only
  logic [7:0] mask;
  logic [7:0] mode;
  logic [7:0] isr;
  logic       cs_q;

  logic [7:0] pend;
  logic [7:0] pend_masked;
  logic       pend_valid;
  logic [2:0] pend_idx;
  logic       isr_valid;
  logic [2:0] isr_idx;
  logic       win;
  logic       wr;
  logic       ack;
  logic       eoi;
  logic [7:0] edge_set;
  logic [7:0] pend_clr;
  logic [7:0] vec_word;

  // Level sources mirror the registered line directly; edge sources use the latch
  assign pend        = (pend_r & mode) | (irq_q & ~mode);
  assign pend_masked = pend & mask;

  prio_enc8 u_pend_enc (
    .in_bits (pend_masked),
    .valid   (pend_valid),
    .idx     (pend_idx)
  );

  prio_enc8 u_isr_enc (
    .in_bits (isr),
    .valid   (isr_valid),
    .idx     (isr_idx)
  );

  // A pending source only wins if it strictly outranks everything in service
  assign win  = pend_valid & (~isr_valid | (pend_idx < isr_idx));
  assign intr = win;

  assign wr  = cs & ~rw;
  assign ack = cs & rw & (AD == IRQ_VECTOR) & ~cs_q & win;
  assign eoi = wr & (AD == IRQ_ISR);

  assign edge_set = irq_in & ~irq_q & mode;

  // Write-clear and acknowledge both retire edge bits; a fresh edge overrides
  always_comb begin
    pend_clr = '0;
    if (wr && AD == IRQ_PEND) pend_clr = pend_clr | DI;
    if (ack)                  pend_clr = pend_clr | irq_onehot(pend_idx);
  end

  // Input sampling and chip-select history for edge and acknowledge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= '0;
      cs_q  <= 1'b0;
    end else begin
      irq_q <= irq_in;
      cs_q  <= cs;
    end
  end

  // Edge pending latch; level-mode bits are held at zero here
  always_ff @(posedge clk) begin
    if (rst) pend_r <= '0;
    else     pend_r <= ((pend_r & ~pend_clr) | edge_set) & mode;
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      mode <= '0;
    end else if (wr) begin
      if (AD == IRQ_MASK) mask <= DI;
      if (AD == IRQ_MODE) mode <= DI;
    end
  end

  // In-service set on acknowledge, lowest bit retired on EOI
  always_ff @(posedge clk) begin
    if (rst) begin
      isr <= '0;
    end else if (ack) begin
      isr <= isr | irq_onehot(pend_idx);
    end else if (eoi && isr_valid) begin
      isr <= isr & ~irq_onehot(isr_idx);
    end
  end

  // Vector word: winner flag in the top bit, source index in the low bits
  always_comb begin
    vec_word = '0;
    if (win) begin
      vec_word[2:0]         = pend_idx;
      vec_word[VEC_ANY_BIT] = 1'b1;
    end
  end

  // Read mux, purely combinational from address and state
  always_comb begin
    DO = '0;
    case (AD)
      IRQ_PEND:   DO = pend;
      IRQ_MASK:   DO = mask;
      IRQ_MODE:   DO = mode;
      IRQ_VECTOR: DO = vec_word;
      IRQ_ISR:    DO = isr;
      IRQ_STATUS: DO = {7'b0, intr};
      default:    DO = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed self-checking bench for irq_ctrl
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic [7:0] irq_in;
  logic       intr;

  int total = 0;
  int bad   = 0;

  irq_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .AD     (AD),
    .DI     (DI),
    .DO     (DO),
    .rw     (rw),
    .cs     (cs),
    .irq_in (irq_in),
    .intr   (intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1 d = DO;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic pulse(input logic [7:0] bits);
    @(negedge clk);
    irq_in = bits;
    @(negedge clk);
    irq_in = '0;
  endtask

  initial begin
    rst = 1'b1; AD = '0; DI = '0; rw = 1'b1; cs = 1'b0; irq_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_intr", {7'b0, intr}, 8'h00);
    for (int a = 0; a < 8; a++) read_chk($sformatf("rst_rd%0d", a), 3'(a), 8'h00);

    // single edge source, acknowledge, EOI
    bus_write(3'd2, 8'h01);
    bus_write(3'd1, 8'h01);
    pulse(8'h01);
    chk("edge_intr_hi", {7'b0, intr}, 8'h01);
    read_chk("edge_pend", 3'd0, 8'h01);
    read_chk("edge_status", 3'd5, 8'h01);
    read_chk("edge_vec", 3'd3, 8'h80);
    read_chk("edge_isr", 3'd4, 8'h01);
    read_chk("edge_pend_clr", 3'd0, 8'h00);
    chk("edge_intr_lo", {7'b0, intr}, 8'h00);
    bus_write(3'd4, 8'h00);
    read_chk("edge_eoi", 3'd4, 8'h00);

    // nesting
    bus_write(3'd2, 8'hFF);
    bus_write(3'd1, 8'hFF);
    pulse(8'h20);
    read_chk("nest_vec5", 3'd3, 8'h85);
    chk("nest_intr_after5", {7'b0, intr}, 8'h00);
    pulse(8'h04);
    chk("nest_intr2", {7'b0, intr}, 8'h01);
    read_chk("nest_vec2", 3'd3, 8'h82);
    read_chk("nest_isr24", 3'd4, 8'h24);
    pulse(8'h40);
    chk("nest_intr6_blocked", {7'b0, intr}, 8'h00);
    read_chk("nest_vec_none", 3'd3, 8'h00);
    bus_write(3'd4, 8'h00);
    read_chk("nest_isr20", 3'd4, 8'h20);
    chk("nest_intr_still0", {7'b0, intr}, 8'h00);
    bus_write(3'd4, 8'h00);
    read_chk("nest_isr00", 3'd4, 8'h00);
    chk("nest_intr6", {7'b0, intr}, 8'h01);
    read_chk("nest_vec6", 3'd3, 8'h86);
    bus_write(3'd4, 8'h00);
    read_chk("nest_isr_final", 3'd4, 8'h00);

    // level mode
    bus_write(3'd2, 8'h00);
    bus_write(3'd1, 8'h08);
    @(negedge clk);
    irq_in = 8'h08;
    @(negedge clk);
    chk("lvl_intr_rise", {7'b0, intr}, 8'h01);
    read_chk("lvl_vec", 3'd3, 8'h83);
    chk("lvl_intr_insvc", {7'b0, intr}, 8'h00);
    bus_write(3'd0, 8'h08);
    read_chk("lvl_pend_nowrite", 3'd0, 8'h08);
    bus_write(3'd4, 8'h00);
    chk("lvl_intr_after_eoi", {7'b0, intr}, 8'h01);
    @(negedge clk);
    irq_in = 8'h00;
    @(negedge clk);
    chk("lvl_intr_fall", {7'b0, intr}, 8'h00);

    // held chip select: one acknowledge only
    bus_write(3'd2, 8'hFF);
    bus_write(3'd1, 8'hFF);
    pulse(8'h12);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; AD = 3'd3;
    #1 chk("hold_vec_first", DO, 8'h81);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      #1 chk($sformatf("hold_vec_c%0d", c), DO, 8'h00);
    end
    @(negedge clk);
    cs = 1'b0;
    read_chk("hold_isr", 3'd4, 8'h02);
    read_chk("hold_pend", 3'd0, 8'h10);

    // edge coinciding with a PEND write-clear
    @(negedge clk);
    irq_in = 8'h80; cs = 1'b1; rw = 1'b0; AD = 3'd0; DI = 8'h80;
    @(negedge clk);
    irq_in = 8'h00; cs = 1'b0; rw = 1'b1;
    read_chk("coinc_pend", 3'd0, 8'h90);
    bus_write(3'd0, 8'h10);
    read_chk("wclr_pend", 3'd0, 8'h80);

    // reset while a handler is in service
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_intr", {7'b0, intr}, 8'h00);
    for (int a = 0; a < 8; a++) read_chk($sformatf("rst2_rd%0d", a), 3'(a), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
